apb_master_arbiter: RTL and testbench

Two-requester APB master that shares one APB slave (register/memory block) between two internal clients. It arbitrates round-robin between the clients and sequences each granted request through APB IDLE/SETUP/ACCESS phases. It waits for PREADY and returns read data and a completion or error status to the winning client. A wait-state timeout keeps the bus from hanging when the slave never responds.

---
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-client round-robin APB master: grants one client, runs SETUP/ACCESS
// on the shared slave, returns rdata/err with a req_done pulse. Registered outputs.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_done,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    grant_id,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state_q, state_d;
  logic   rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic   grant_q, grant_d;
  logic   psel_q, psel_d;
  logic   penable_q, penable_d;
  logic   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [1:0] done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic   err_q, err_d;
  logic   busy_q, busy_d;

  logic win;
  logic to_hit;

  // rr_q names the tie winner; a lone requester always wins
  always_comb begin
    unique case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = rr_q;
    endcase
  end

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TLAST);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;
    busy_d    = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d  = win;
          pwrite_d = req_write[win];
          paddr_d  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                         : req_addr[ADDR_WIDTH-1:0];
          pwdata_d = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                         : req_wdata[DATA_WIDTH-1:0];
          psel_d   = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY wins over a timeout landing in the same cycle
        if (PREADY || to_hit) begin
          done_d    = grant_q ? 2'b10 : 2'b01;
          rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
          err_d     = !PREADY;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          rr_d      = ~grant_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign req_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: random client traffic against a memory
// slave with programmable wait states, checked by a transaction model.
module tb_apb_master_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_done;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          grant_id;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  apb_master_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_done(req_done),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .grant_id(grant_id),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave: memory plus per-client wait-state count
  logic [DW-1:0] smem [256];
  int wait_n [2];
  int acc_cnt = 0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    PREADY = PSEL && PENABLE && (acc_cnt == wait_n[grant_id] + 1);
    PRDATA = smem[PADDR];
  end

  always @(posedge PCLK)
    if (PRESETn && PSEL && PENABLE && PREADY && PWRITE)
      smem[PADDR] <= PWDATA;

  // reference model
  logic [DW-1:0] exp_mem [256];
  int tie = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  task automatic do_txn(input logic [1:0] vm, input logic [1:0] wr,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input int w0, input int w1, input bit drop);
    int order [2];
    int n;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    req_write = wr;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    wait_n[0] = w0;
    wait_n[1] = w1;
    req_valid = vm;
    if (vm == 2'b11) begin
      order[0] = tie; order[1] = 1 - tie; n = 2;
    end else begin
      order[0] = vm[1] ? 1 : 0; order[1] = 0; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      int win;
      int lat;
      bit got;
      bit e;
      win = order[k];
      e   = (wait_n[win] >= TO);
      lat = e ? 2 + TO : 3 + wait_n[win];
      got = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
        @(negedge PCLK);
        if (drop && k == 0 && c == 1) req_valid[win] = 1'b0;
        if (req_done != 2'b00) begin
          logic [DW-1:0] er;
          got = 1;
          er = (e || wr[win]) ? '0 : exp_mem[a[win]];
          if (!e && wr[win]) exp_mem[a[win]] = d[win];
          chk("done_lat", 64'(c), 64'(lat));
          chk("done_bit", 64'(req_done), 64'(2'b01 << win));
          chk("rdata", 64'(rsp_rdata), 64'(er));
          chk("err", 64'(rsp_err), 64'(e));
          chk("grant_id", 64'(grant_id), 64'(win));
          chk("idle_gap", 64'({PSEL, PENABLE, busy}), 64'(0));
          last_rdata = er;
          last_err   = e;
          tie = 1 - win;
          req_valid[win] = 1'b0;
        end else if (c < lat) begin
          chk("psel", 64'(PSEL), 64'(1));
          chk("penable", 64'(PENABLE), 64'(c > 1));
          chk("busy", 64'(busy), 64'(1));
          chk("paddr", 64'(PADDR), 64'(a[win]));
          chk("pwrite", 64'(PWRITE), 64'(wr[win]));
          if (wr[win]) chk("pwdata", 64'(PWDATA), 64'(d[win]));
        end
      end
      if (!got) chk("done_timeout", 64'(0), 64'(1));
    end
    @(negedge PCLK);
    chk("done_pulse", 64'(req_done), 64'(0));
    chk("no_regrant", 64'(PSEL), 64'(0));
    chk("rsp_hold", 64'({last_err, rsp_rdata}), 64'({rsp_err, last_rdata}));
    chk("rsp_hold_v", 64'({rsp_err, rsp_rdata}), 64'({last_err, last_rdata}));
  endtask

  function automatic int rnd_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 4);
    if (r == 7) return 15;
    if (r == 8) return 16;
    return 999;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      smem[i] = '0;
      exp_mem[i] = '0;
    end
    wait_n[0] = 0;
    wait_n[1] = 0;
    PREADY = 1'b0;
    PRDATA = '0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset_out", 64'({req_done, rsp_rdata, rsp_err, busy, grant_id,
        PSEL, PENABLE, PWRITE}), 64'(0));
    chk("reset_bus", 64'({PADDR, PWDATA}), 64'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);

    // zero-wait write then read from client 0
    do_txn(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 0, 0, 0, 0);
    do_txn(2'b01, 2'b00, 8'h10, 8'h00, 0, 0, 0, 0, 0);
    chk("rd_back", 64'(rsp_rdata), 64'(32'hDEADBEEF));

    // client 1: write then read with 3 wait states
    do_txn(2'b10, 2'b10, 8'h00, 8'h20, 0, 32'h12345678, 0, 0, 0);
    do_txn(2'b10, 2'b00, 8'h00, 8'h20, 0, 0, 0, 3, 0);
    chk("rd_wait", 64'(rsp_rdata), 64'(32'h12345678));

    // timeout on a read
    do_txn(2'b01, 2'b00, 8'h10, 8'h00, 0, 0, 999, 0, 0);

    // client drops req_valid during SETUP
    do_txn(2'b01, 2'b01, 8'h05, 8'h00, 32'hCAFE0005, 0, 1, 0, 1);

    // continuous contention: both hold req_valid
    begin
      int exp_g;
      int cnt;
      int c;
      req_write = 2'b00;
      req_addr  = {8'h20, 8'h10};
      wait_n[0] = 0;
      wait_n[1] = 0;
      req_valid = 2'b11;
      exp_g = tie;
      cnt = 0;
      c = 0;
      for (int t = 0; t < 60 && cnt < 4; t++) begin
        @(negedge PCLK);
        c++;
        if (req_done != 2'b00) begin
          chk("cont_lat", 64'(c), 64'(3));
          chk("cont_bit", 64'(req_done), 64'(2'b01 << exp_g));
          chk("cont_psel", 64'(PSEL), 64'(0));
          chk("cont_rd", 64'(rsp_rdata),
              64'(exp_g ? exp_mem[8'h20] : exp_mem[8'h10]));
          last_rdata = exp_g ? exp_mem[8'h20] : exp_mem[8'h10];
          last_err = 1'b0;
          exp_g = 1 - exp_g;
          cnt++;
          c = 0;
          if (cnt == 4) req_valid = 2'b00;
        end
      end
      chk("cont_count", 64'(cnt), 64'(4));
      tie = exp_g;
      @(negedge PCLK);
      chk("cont_stop", 64'(PSEL), 64'(0));
    end

    // random traffic
    for (int it = 0; it < 60; it++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      do_txn(vm, 2'($urandom),
             8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
             $urandom, $urandom, rnd_wait(), rnd_wait(), 0);
    end

    // asynchronous reset in ACCESS
    req_write = 2'b01;
    req_addr  = {8'h00, 8'h30};
    req_wdata = {32'h0, 32'hBAD0BAD0};
    wait_n[0] = 999;
    req_valid = 2'b01;
    repeat (4) @(negedge PCLK);
    chk("pre_rst_acc", 64'({PSEL, PENABLE}), 64'(2'b11));
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_async", 64'({PSEL, PENABLE, busy, req_done}), 64'(0));
    req_valid = 2'b00;
    @(negedge PCLK);
    PRESETn = 1'b1;
    tie = 0;
    last_rdata = '0;
    last_err = 1'b0;
    @(negedge PCLK);
    chk("rst_nodone", 64'(req_done), 64'(0));
    chk("rst_nowrite", 64'(smem[8'h30]), 64'(0));
    do_txn(2'b11, 2'b00, 8'h10, 8'h20, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
